// File: rtl/rv32i_bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_bp_pkg
//  Description : Shared branch-predictor types and constants for the RV32I
//                gshare predictor and its resolve tracking logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32i_bp_pkg;

    // 2-bit saturating counter encodings held in the pattern history table
    typedef enum logic [1:0] {
        STRONGLY_NOT_TAKEN = 2'b00,
        WEAKLY_NOT_TAKEN   = 2'b01,
        WEAKLY_TAKEN       = 2'b10,
        STRONGLY_TAKEN     = 2'b11
    } bp_counter_e;

    // Default PHT index width
    localparam int          c_gshare_bits_default = 8;

    // Default PC / target width
    localparam int          c_xlen_default        = 32;

    // Size of one RV32I instruction in bytes (fall-through increment)
    localparam int unsigned c_insn_size           = 4;

    // Layout of one in-flight prediction at default widths. The FIFO stores
    // a packed vector with exactly this field order: {taken, index, pc, target}.
    typedef struct packed {
        logic                             taken;
        logic [c_gshare_bits_default-1:0] index;
        logic [c_xlen_default-1:0]        pc;
        logic [c_xlen_default-1:0]        target;
    } bp_entry_t;

endpackage : rv32i_bp_pkg
`default_nettype wire

// File: rtl/branch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : branch_fifo
//  Description : In-order storage for in-flight branch predictions. Supports
//                push, pop of the head entry and a clear that empties the
//                FIFO (clear wins over push and pop in the same cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 73
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_head_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;

    // Full/empty come straight from the count register, so acceptance never
    // depends on a same-cycle pop (no bypass).
    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push_ok = i_push && !w_full && !i_clear;
    assign w_pop_ok  = i_pop && !w_empty && !i_clear;

    // Entry storage; written only on an accepted push
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking; clear discards everything still queued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full      = w_full;

endmodule : branch_fifo
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Tracks conditional branches from prediction to resolution,
//                compares the oldest prediction with the resolved outcome and
//                issues a registered predictor update, mispredict redirect and
//                younger-branch flush. Keeps saturating statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import rv32i_bp_pkg::*;
#(
    parameter int GSHARE_BITS_NUM      = c_gshare_bits_default,
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int DEPTH                = 4
)
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pred_valid_i,
    output logic                            pred_ready_o,
    input  logic                            pred_taken_i,
    input  logic [GSHARE_BITS_NUM-1:0]      pred_index_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pred_pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pred_target_i,
    input  logic                            res_valid_i,
    input  logic                            res_taken_i,
    input  logic                            flush_i,
    output logic                            upd_valid_o,
    output logic [GSHARE_BITS_NUM-1:0]      upd_index_o,
    output logic                            upd_taken_o,
    output logic                            mispredict_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic                            err_o,
    output logic [31:0]                     branch_cnt_o,
    output logic [31:0]                     mispred_cnt_o
);

    localparam int c_entry_w = 1 + GSHARE_BITS_NUM + 2 * OPTION_OPERAND_WIDTH;
    localparam int c_cnt_w   = $clog2(DEPTH) + 1;

    logic [c_entry_w-1:0]            w_push_data;
    logic [c_entry_w-1:0]            w_head_data;
    logic [c_cnt_w-1:0]              w_count;
    logic                            w_full;

    logic                            w_head_taken;
    logic [GSHARE_BITS_NUM-1:0]      w_head_index;
    logic [OPTION_OPERAND_WIDTH-1:0] w_head_pc;
    logic [OPTION_OPERAND_WIDTH-1:0] w_head_target;

    logic                            w_has_entry;
    logic                            w_resolve;
    logic                            w_mis;
    logic                            w_clear;
    logic                            w_err_event;
    logic [OPTION_OPERAND_WIDTH-1:0] w_redirect;

    logic                            r_upd_valid;
    logic [GSHARE_BITS_NUM-1:0]      r_upd_index;
    logic                            r_upd_taken;
    logic                            r_mispredict;
    logic [OPTION_OPERAND_WIDTH-1:0] r_redirect_pc;
    logic                            r_err;
    logic [31:0]                     r_branch_cnt;
    logic [31:0]                     r_mispred_cnt;

    assign w_push_data = {pred_taken_i, pred_index_i, pred_pc_i, pred_target_i};
    assign {w_head_taken, w_head_index, w_head_pc, w_head_target} = w_head_data;

    // An external flush cancels any resolution presented in the same cycle
    assign w_has_entry = (w_count != '0);
    assign w_resolve   = res_valid_i && w_has_entry && !flush_i;
    assign w_err_event = res_valid_i && !w_has_entry && !flush_i;
    assign w_mis       = w_head_taken != res_taken_i;

    // Everything behind the head is younger than a mispredicted branch, so a
    // mispredict empties the FIFO just like an external flush.
    assign w_clear     = flush_i || (w_resolve && w_mis);

    // Fall-through wraps naturally at the top of the address space
    assign w_redirect  = res_taken_i ? w_head_target
                                     : w_head_pc + OPTION_OPERAND_WIDTH'(c_insn_size);

    branch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_branch_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (pred_valid_i),
        .i_push_data (w_push_data),
        .i_pop       (w_resolve),
        .i_clear     (w_clear),
        .o_head_data (w_head_data),
        .o_count     (w_count),
        .o_full      (w_full)
    );

    // Registered predictor update and redirect; pulses last one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_valid   <= 1'b0;
            r_upd_index   <= '0;
            r_upd_taken   <= 1'b0;
            r_mispredict  <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_upd_valid  <= w_resolve;
            r_mispredict <= w_resolve && w_mis;
            if (w_resolve) begin
                r_upd_index <= w_head_index;
                r_upd_taken <= res_taken_i;
            end
            if (w_resolve && w_mis) begin
                r_redirect_pc <= w_redirect;
            end
        end
    end

    // Sticky error: a resolution arrived with nothing in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_event) begin
            r_err <= 1'b1;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_resolve && w_mis && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign pred_ready_o  = !w_full;
    assign count_o       = w_count;
    assign err_o         = r_err;
    assign upd_valid_o   = r_upd_valid;
    assign upd_index_o   = r_upd_index;
    assign upd_taken_o   = r_upd_taken;
    assign mispredict_o  = r_mispredict;
    assign redirect_pc_o = r_redirect_pc;
    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule : branch_resolve_unit
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Scoreboard bench for branch_resolve_unit. A reference model
//                of the in-flight queue predicts each update; expectations
//                are queued on drive and compared when the update appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int c_depth = 4;

    logic        clk;
    logic        rst;
    logic        pred_valid_i;
    logic        pred_ready_o;
    logic        pred_taken_i;
    logic [7:0]  pred_index_i;
    logic [31:0] pred_pc_i;
    logic [31:0] pred_target_i;
    logic        res_valid_i;
    logic        res_taken_i;
    logic        flush_i;
    logic        upd_valid_o;
    logic [7:0]  upd_index_o;
    logic        upd_taken_o;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [2:0]  count_o;
    logic        err_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    branch_resolve_unit #(
        .GSHARE_BITS_NUM      (8),
        .OPTION_OPERAND_WIDTH (32),
        .DEPTH                (c_depth)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid_i  (pred_valid_i),
        .pred_ready_o  (pred_ready_o),
        .pred_taken_i  (pred_taken_i),
        .pred_index_i  (pred_index_i),
        .pred_pc_i     (pred_pc_i),
        .pred_target_i (pred_target_i),
        .res_valid_i   (res_valid_i),
        .res_taken_i   (res_taken_i),
        .flush_i       (flush_i),
        .upd_valid_o   (upd_valid_o),
        .upd_index_o   (upd_index_o),
        .upd_taken_o   (upd_taken_o),
        .mispredict_o  (mispredict_o),
        .redirect_pc_o (redirect_pc_o),
        .count_o       (count_o),
        .err_o         (err_o),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [7:0]  idx;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic [7:0]  idx;
        logic        taken;
        logic        mis;
        logic [31:0] redirect;
    } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    logic        m_err;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    int          checks;
    int          failures;

    // Single comparison point: counts and reports
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Update monitor: sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("upd_valid", {63'd0, upd_valid_o}, 64'd1);
            chk("upd_index", {56'd0, upd_index_o}, {56'd0, e.idx});
            chk("upd_taken", {63'd0, upd_taken_o}, {63'd0, e.taken});
            chk("mispredict", {63'd0, mispredict_o}, {63'd0, e.mis});
            if (e.mis) chk("redirect_pc", {32'd0, redirect_pc_o}, {32'd0, e.redirect});
        end else begin
            chk("no_upd_valid", {63'd0, upd_valid_o}, 64'd0);
            chk("no_mispredict", {63'd0, mispredict_o}, 64'd0);
        end
    end

    // One clock cycle of stimulus with model update and state checks
    task automatic cyc(input logic r, input logic pv, input logic pt, input logic [7:0] pidx,
                       input logic [31:0] ppc, input logic [31:0] ptgt,
                       input logic rv, input logic rt, input logic fl);
        logic push_ok;
        logic resolve;
        ent_t h;
        exp_t e;
        ent_t n;
        push_ok = pv && (mq.size() != c_depth);
        resolve = rv && (mq.size() != 0) && !fl;
        n.taken = pt; n.idx = pidx; n.pc = ppc; n.tgt = ptgt;
        if (r) begin
            mq.delete();
            m_err = 1'b0; m_br = 32'd0; m_mis = 32'd0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (rv && mq.size() == 0) m_err = 1'b1;
            if (resolve) begin
                h = mq.pop_front();
                e.idx = h.idx;
                e.taken = rt;
                e.mis = (h.taken != rt);
                e.redirect = rt ? h.tgt : h.pc + 32'd4;
                sb.push_back(e);
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 32'd1;
                if (e.mis) begin
                    if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 32'd1;
                    mq.delete();
                end else if (push_ok) begin
                    mq.push_back(n);
                end
            end else if (push_ok) begin
                mq.push_back(n);
            end
        end
        rst = r; pred_valid_i = pv; pred_taken_i = pt; pred_index_i = pidx;
        pred_pc_i = ppc; pred_target_i = ptgt; res_valid_i = rv; res_taken_i = rt; flush_i = fl;
        @(posedge clk);
        @(negedge clk);
        chk("count", {61'd0, count_o}, 64'(mq.size()));
        chk("pred_ready", {63'd0, pred_ready_o}, {63'd0, mq.size() != c_depth});
        chk("err", {63'd0, err_o}, {63'd0, m_err});
        chk("branch_cnt", {32'd0, branch_cnt_o}, {32'd0, m_br});
        chk("mispred_cnt", {32'd0, mispred_cnt_o}, {32'd0, m_mis});
    endtask

    task automatic push(input logic pt, input logic [7:0] idx, input logic [31:0] pc, input logic [31:0] tgt);
        cyc(1'b0, 1'b1, pt, idx, pc, tgt, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input logic rt);
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b1, rt, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_upd_valid"}, {63'd0, upd_valid_o}, 64'd0);
        chk({tag, "_upd_index"}, {56'd0, upd_index_o}, 64'd0);
        chk({tag, "_upd_taken"}, {63'd0, upd_taken_o}, 64'd0);
        chk({tag, "_mispredict"}, {63'd0, mispredict_o}, 64'd0);
        chk({tag, "_redirect"}, {32'd0, redirect_pc_o}, 64'd0);
        chk({tag, "_ready"}, {63'd0, pred_ready_o}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        m_err = 1'b0; m_br = 32'd0; m_mis = 32'd0;
        rst = 1'b1; pred_valid_i = 1'b0; pred_taken_i = 1'b0; pred_index_i = 8'd0;
        pred_pc_i = 32'd0; pred_target_i = 32'd0; res_valid_i = 1'b0; res_taken_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk_all_zero("reset");

        // Correct taken prediction
        push(1'b1, 8'h3A, 32'h100, 32'h180);
        resolve(1'b1);

        // Taken predicted, resolved not-taken: fall-through redirect
        push(1'b1, 8'h11, 32'h200, 32'h280);
        resolve(1'b0);

        // Three in flight, mispredict on the oldest while a 4th is pushed
        push(1'b0, 8'h01, 32'h300, 32'h380);
        push(1'b0, 8'h02, 32'h304, 32'h390);
        push(1'b0, 8'h03, 32'h308, 32'h3A0);
        cyc(1'b0, 1'b1, 1'b1, 8'h04, 32'h30C, 32'h3B0, 1'b1, 1'b1, 1'b0);
        resolve(1'b0);

        // Fill to capacity, overflow push ignored, drain in order
        push(1'b1, 8'h40, 32'h400, 32'h500);
        push(1'b0, 8'h41, 32'h404, 32'h504);
        push(1'b1, 8'h42, 32'h408, 32'h508);
        push(1'b0, 8'h43, 32'h40C, 32'h50C);
        push(1'b1, 8'h44, 32'h410, 32'h510);
        resolve(1'b1);
        resolve(1'b0);
        resolve(1'b1);
        resolve(1'b0);

        // Full FIFO with simultaneous pop and push: push still refused
        push(1'b0, 8'h50, 32'h600, 32'h700);
        push(1'b0, 8'h51, 32'h604, 32'h704);
        push(1'b0, 8'h52, 32'h608, 32'h708);
        push(1'b0, 8'h53, 32'h60C, 32'h70C);
        cyc(1'b0, 1'b1, 1'b1, 8'h54, 32'h610, 32'h710, 1'b1, 1'b0, 1'b0);
        resolve(1'b0);
        resolve(1'b0);
        resolve(1'b0);

        // Correct resolve with same-cycle push keeps count
        push(1'b1, 8'h60, 32'h800, 32'h900);
        cyc(1'b0, 1'b1, 1'b0, 8'h61, 32'h804, 32'h904, 1'b1, 1'b1, 1'b0);
        resolve(1'b0);

        // External flush with push and resolve in the same cycle
        push(1'b1, 8'h70, 32'hA00, 32'hB00);
        push(1'b1, 8'h71, 32'hA04, 32'hB04);
        cyc(1'b0, 1'b1, 1'b1, 8'h72, 32'hA08, 32'hB08, 1'b1, 1'b0, 1'b1);
        idle();

        // Fall-through at the top of the address space wraps to zero
        push(1'b1, 8'h80, 32'hFFFF_FFFC, 32'h1000);
        resolve(1'b0);

        // Saturated branch counter holds
        force dut.r_branch_cnt = 32'hFFFF_FFFF;
        m_br = 32'hFFFF_FFFF;
        idle();
        release dut.r_branch_cnt;
        push(1'b0, 8'h90, 32'hC00, 32'hD00);
        resolve(1'b1);

        // Reset mid-stream suppresses the pending update
        push(1'b1, 8'hA0, 32'hE00, 32'hF00);
        push(1'b1, 8'hA1, 32'hE04, 32'hF04);
        cyc(1'b1, 1'b1, 1'b1, 8'hA2, 32'hE08, 32'hF08, 1'b1, 1'b0, 1'b0);
        chk_all_zero("midrst");

        // Normal operation after reset
        push(1'b0, 8'hB0, 32'h1200, 32'h1300);
        resolve(1'b1);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_branch_resolve_unit
`default_nettype wire
